// File: rtl/lattice_value_buffer.sv
// Neighbour-pairing buffer: pairs each held word of node values with its i+1 neighbours,
// borrowing the top neighbour from the next word or, at the end of a level, from UP_FILL.
module lattice_value_buffer #(
  parameter int               LANES     = 4,
  parameter int               WIDTH     = 64,
  parameter int               CNT_WIDTH = 16,
  parameter logic [WIDTH-1:0] UP_FILL   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [LANES*WIDTH-1:0] out_down,
  output logic [LANES*WIDTH-1:0] out_up,
  output logic [CNT_WIDTH-1:0]   out_count
);

  localparam int DW = LANES * WIDTH;

  typedef enum logic [1:0] {
    EMPTY,
    HOLD,
    FLUSH
  } state_t;

  state_t                     state;
  logic [DW-1:0]              hold;
  logic                       hold_valid;
  logic                       hold_last;
  logic [CNT_WIDTH-1:0]       cnt;
  logic                       accept;
  logic [(LANES-1)*WIDTH-1:0] hold_shift;

  // The buffer state is fully encoded by the two hold flags.
  always_comb begin
    state = EMPTY;
    if (hold_valid) begin
      state = hold_last ? FLUSH : HOLD;
    end
  end

  assign in_ready   = !reset && (state != FLUSH);
  assign accept     = in_valid && in_ready;
  assign hold_shift = hold[DW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_down   <= '0;
      out_up     <= '0;
      out_count  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        EMPTY: begin
          if (accept) begin
            hold       <= in_data;
            hold_last  <= in_last;
            hold_valid <= 1'b1;
          end
        end
        HOLD: begin
          // The incoming word supplies the top-lane neighbour of the held word.
          if (accept) begin
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_down  <= hold;
            out_up    <= {in_data[WIDTH-1:0], hold_shift};
            out_count <= cnt;
            cnt       <= cnt + 1'b1;
            hold      <= in_data;
            hold_last <= in_last;
          end
        end
        FLUSH: begin
          out_valid  <= 1'b1;
          out_last   <= 1'b1;
          out_down   <= hold;
          out_up     <= {UP_FILL, hold_shift};
          out_count  <= cnt;
          cnt        <= '0;
          hold_valid <= 1'b0;
          hold_last  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lattice_value_buffer.sv
// Directed bench for lattice_value_buffer: LANES=4, WIDTH=8, plus a CNT_WIDTH=2 copy
// that sees the same stimulus to exercise counter wrap.
module tb_lattice_value_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_last;
  logic [31:0] in_data;

  logic        in_ready,  out_valid,  out_last;
  logic [31:0] out_down,  out_up;
  logic [15:0] out_count;

  logic        in_ready2, out_valid2, out_last2;
  logic [31:0] out_down2, out_up2;
  logic [1:0]  out_count2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] dq[$];
  logic [31:0] uq[$];
  int          cq[$];
  logic        lq[$];
  int          pc[$];
  int          c2q[$];
  logic        l2q[$];
  int          rq[$];

  lattice_value_buffer #(.LANES(4), .WIDTH(8), .CNT_WIDTH(16), .UP_FILL(8'h00)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .out_valid(out_valid), .out_last(out_last), .out_down(out_down),
    .out_up(out_up), .out_count(out_count)
  );

  lattice_value_buffer #(.LANES(4), .WIDTH(8), .CNT_WIDTH(2), .UP_FILL(8'h00)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
    .in_data(in_data), .out_valid(out_valid2), .out_last(out_last2), .out_down(out_down2),
    .out_up(out_up2), .out_count(out_count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every presented pair and every cycle in which the buffer refuses input.
  always @(negedge clk) begin
    if (out_valid) begin
      dq.push_back(out_down);
      uq.push_back(out_up);
      cq.push_back(int'(out_count));
      lq.push_back(out_last);
      pc.push_back(cyc);
    end
    if (out_valid2) begin
      c2q.push_back(int'(out_count2));
      l2q.push_back(out_last2);
    end
    if (!reset && !in_ready) rq.push_back(cyc);
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clearQueues();
    dq.delete(); uq.delete(); cq.delete(); lq.delete(); pc.delete();
    c2q.delete(); l2q.delete(); rq.delete();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a word and holds it until the buffer takes it; returns the cycle of acceptance.
  task automatic applyStimulus(input logic [31:0] data, input logic last, output int acc_cyc);
    logic r;
    logic accepted;
    r        = 1'b0;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    for (int i = 0; i < 20 && !accepted; i++) begin
      r = in_ready && in_ready2;
      @(posedge clk);
      #1;
      if (r) accepted = 1'b1;
    end
    if (!accepted) checkOutput("accept_timeout", 64'(r), 64'd1);
    acc_cyc = cyc;
  endtask

  task automatic checkPair(input int idx, input logic [31:0] down, input logic [31:0] up,
                           input int count, input logic last);
    if (idx < dq.size()) begin
      checkOutput($sformatf("down%0d", idx), 64'(dq[idx]), 64'(down));
      checkOutput($sformatf("up%0d", idx), 64'(uq[idx]), 64'(up));
      checkOutput($sformatf("count%0d", idx), 64'(cq[idx]), 64'(count));
      checkOutput($sformatf("last%0d", idx), 64'(lq[idx]), 64'(last));
    end
  endtask

  initial begin
    int c0;
    int a, a1, a2;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_down", 64'(out_down), 64'd0);
    checkOutput("rst_out_up", 64'(out_up), 64'd0);
    checkOutput("rst_out_count", 64'(out_count), 64'd0);
    reset = 1'b0;
    idle(1);
    checkOutput("post_rst_ready", 64'(in_ready), 64'd1);

    // Two words back-to-back, second one closes the level.
    clearQueues();
    c0 = cyc;
    applyStimulus(32'h04030201, 1'b0, a);
    applyStimulus(32'h08070605, 1'b1, a);
    idle(4);
    checkOutput("t1_pairs", 64'(dq.size()), 64'd2);
    checkPair(0, 32'h04030201, 32'h05040302, 0, 1'b0);
    checkPair(1, 32'h08070605, 32'h00080706, 1, 1'b1);
    if (pc.size() > 0) checkOutput("t1_latency", 64'(pc[0] - c0), 64'd2);

    // Single-word level.
    clearQueues();
    applyStimulus(32'h09090909, 1'b1, a);
    idle(4);
    checkOutput("t2_pairs", 64'(dq.size()), 64'd1);
    checkPair(0, 32'h09090909, 32'h00090909, 0, 1'b1);
    checkOutput("t2_ready_low_n", 64'(rq.size()), 64'd1);
    if (rq.size() > 0) checkOutput("t2_ready_low_cyc", 64'(rq[0]), 64'(a));

    // Same as the first level but with an idle cycle between the words.
    clearQueues();
    c0 = cyc;
    applyStimulus(32'h04030201, 1'b0, a);
    idle(1);
    applyStimulus(32'h08070605, 1'b1, a);
    idle(4);
    checkOutput("t3_pairs", 64'(dq.size()), 64'd2);
    checkPair(0, 32'h04030201, 32'h05040302, 0, 1'b0);
    checkPair(1, 32'h08070605, 32'h00080706, 1, 1'b1);
    if (pc.size() > 0) checkOutput("t3_latency", 64'(pc[0] - c0), 64'd3);

    // Two levels back-to-back with in_valid kept high.
    clearQueues();
    applyStimulus(32'h04030201, 1'b0, a);
    applyStimulus(32'h08070605, 1'b0, a);
    applyStimulus(32'h0C0B0A09, 1'b1, a1);
    applyStimulus(32'h14131211, 1'b0, a);
    applyStimulus(32'h18171615, 1'b1, a2);
    idle(4);
    checkOutput("t4_pairs", 64'(dq.size()), 64'd5);
    checkPair(0, 32'h04030201, 32'h05040302, 0, 1'b0);
    checkPair(1, 32'h08070605, 32'h09080706, 1, 1'b0);
    checkPair(2, 32'h0C0B0A09, 32'h000C0B0A, 2, 1'b1);
    checkPair(3, 32'h14131211, 32'h15141312, 0, 1'b0);
    checkPair(4, 32'h18171615, 32'h00181716, 1, 1'b1);
    checkOutput("t4_ready_low_n", 64'(rq.size()), 64'd2);
    if (rq.size() > 1) begin
      checkOutput("t4_ready_low0", 64'(rq[0]), 64'(a1));
      checkOutput("t4_ready_low1", 64'(rq[1]), 64'(a2));
    end

    // Reset while a word is held mid-level.
    applyStimulus(32'h04030201, 1'b0, a);
    applyStimulus(32'h08070605, 1'b0, a);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    clearQueues();
    checkOutput("t5_ready", 64'(in_ready), 64'd0);
    checkOutput("t5_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_down", 64'(out_down), 64'd0);
    checkOutput("t5_up", 64'(out_up), 64'd0);
    checkOutput("t5_count", 64'(out_count), 64'd0);
    checkOutput("t5_last", 64'(out_last), 64'd0);
    reset = 1'b0;
    idle(3);
    checkOutput("t5_no_pair", 64'(dq.size()), 64'd0);
    applyStimulus(32'h0D0D0D0D, 1'b1, a);
    idle(4);
    checkOutput("t5_pairs", 64'(dq.size()), 64'd1);
    checkPair(0, 32'h0D0D0D0D, 32'h000D0D0D, 0, 1'b1);

    // Six-word level: the 2-bit counter copy must wrap.
    clearQueues();
    for (int i = 0; i < 6; i++) begin
      applyStimulus({4{8'(i + 1)}}, (i == 5), a);
    end
    idle(4);
    checkOutput("t6_pairs2", 64'(c2q.size()), 64'd6);
    if (c2q.size() == 6) begin
      checkOutput("t6_c0", 64'(c2q[0]), 64'd0);
      checkOutput("t6_c1", 64'(c2q[1]), 64'd1);
      checkOutput("t6_c2", 64'(c2q[2]), 64'd2);
      checkOutput("t6_c3", 64'(c2q[3]), 64'd3);
      checkOutput("t6_c4", 64'(c2q[4]), 64'd0);
      checkOutput("t6_c5", 64'(c2q[5]), 64'd1);
      checkOutput("t6_last4", 64'(l2q[4]), 64'd0);
      checkOutput("t6_last5", 64'(l2q[5]), 64'd1);
    end
    checkOutput("t6_wide_pairs", 64'(cq.size()), 64'd6);
    if (cq.size() == 6) checkOutput("t6_wide_c5", 64'(cq[5]), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
